multiply_seq: RTL and testbench

Parametrised iterative shift-add multiplier with signed/unsigned mode, an optional multiply-accumulate path and a sticky overflow flag. It is the next generation of the `multiply` block and keeps its `start`/`ready` handshake and `A`/`B`/`Y` naming. It sits in the matrix datapath as the per-element product/dot-product engine. It is sized for area, not throughput: one operation per WIDTH+2 cycles.

---
 rtl/multiply_seq_if.sv | 30 +++
 rtl/multiply_seq.sv | 127 ++++++++++++
 tb/tb_multiply_seq.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/multiply_seq_if.sv
// Handshake and data bundle for the iterative multiply/accumulate engine.
// The requester drives the master side; the engine uses the slave side.
interface multiply_seq_if #(
   parameter int WIDTH = 16,
   parameter int GUARD = 4
);
   localparam int ACCWIDTH = 2*WIDTH + GUARD;

   logic                start;
   logic [WIDTH-1:0]    A;
   logic [WIDTH-1:0]    B;
   logic                is_signed;
   logic                accumulate;
   logic                clear;
   logic                ready;
   logic                done;
   logic [2*WIDTH-1:0]  Y;
   logic [ACCWIDTH-1:0] acc;
   logic                overflow;

   modport master (
      output start, A, B, is_signed, accumulate, clear,
      input  ready, done, Y, acc, overflow
   );

   modport slave (
      input  start, A, B, is_signed, accumulate, clear,
      output ready, done, Y, acc, overflow
   );
endinterface

// File: rtl/multiply_seq.sv
// Iterative shift-add multiplier with signed/unsigned operands, optional
// accumulate into a guarded accumulator and a sticky overflow flag.
module multiply_seq #(
   parameter int WIDTH = 16,
   parameter int GUARD = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   multiply_seq_if.slave  bus
);
   localparam int ACCWIDTH = 2*WIDTH + GUARD;
   localparam int PW       = 2*WIDTH;
   localparam int CW       = $clog2(WIDTH+1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t              state, state_n;
   logic [CW-1:0]       cnt;
   logic [PW-1:0]       mcand;
   logic [WIDTH-1:0]    mplier;
   logic [PW-1:0]       pp;
   logic                neg_q;
   logic                sgn_q;
   logic                accum_q;
   logic [PW-1:0]       y_q;
   logic [ACCWIDTH-1:0] acc_q;
   logic                ovf_q;

   logic [WIDTH-1:0]    mag_a, mag_b;
   logic [PW-1:0]       pp_n, y_n;
   logic [ACCWIDTH-1:0] y_ext;
   logic [ACCWIDTH:0]   sum;
   logic                add_ovf;
   logic                last;

   // Negating -2^(WIDTH-1) in WIDTH bits yields 2^(WIDTH-1), which is
   // exactly the correct magnitude when the register is read as unsigned.
   assign mag_a = (bus.is_signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
   assign mag_b = (bus.is_signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;
   assign last  = (cnt == CW'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // NOTE: every signal written in a combinational block gets a default
   // first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (bus.start) state_n = CALC;
         CALC:    if (last)      state_n = DONE;
         DONE:                   state_n = IDLE;
         default:                state_n = IDLE;
      endcase
   end

   always_comb begin
      pp_n    = mplier[0] ? pp + mcand : pp;
      y_n     = neg_q ? -pp_n : pp_n;
      y_ext   = sgn_q ? ACCWIDTH'($signed(y_n)) : ACCWIDTH'(y_n);
      sum     = {1'b0, acc_q} + {1'b0, y_ext};
      add_ovf = sgn_q ? ((acc_q[ACCWIDTH-1] == y_ext[ACCWIDTH-1]) &&
                         (sum[ACCWIDTH-1]   != acc_q[ACCWIDTH-1]))
                      : sum[ACCWIDTH];
   end

   // NOTE: only a handful of datapath flops exist, so all of them take the
   // async reset; that keeps simulation X-free and an abort fully clean.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         pp      <= '0;
         neg_q   <= 1'b0;
         sgn_q   <= 1'b0;
         accum_q <= 1'b0;
         y_q     <= '0;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register sees
         // the pre-edge values of the others regardless of statement order.
         case (state)
            IDLE: if (bus.start) begin
               mcand   <= PW'(mag_a);
               mplier  <= mag_b;
               pp      <= '0;
               cnt     <= CW'(WIDTH);
               neg_q   <= bus.is_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
               sgn_q   <= bus.is_signed;
               accum_q <= bus.accumulate;
            end
            CALC: begin
               pp     <= pp_n;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt - CW'(1);
               // The final iteration publishes Y/acc together with entry to DONE.
               if (last) begin
                  y_q <= y_n;
                  if (accum_q) begin
                     acc_q <= sum[ACCWIDTH-1:0];
                     ovf_q <= ovf_q | add_ovf;
                  end else begin
                     acc_q <= y_ext;
                  end
               end
            end
            default: ;
         endcase
         // Placed last so a coincident clear overrides the accumulator update.
         if (bus.clear) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
         end
      end
   end

   assign bus.ready    = (state == IDLE);
   assign bus.done     = (state == DONE);
   assign bus.Y        = y_q;
   assign bus.acc      = acc_q;
   assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_multiply_seq.sv
// Directed bench for multiply_seq at WIDTH=8, GUARD=4: vector table plus
// hand-written sequences for accumulate, busy, reset-abort and clear cases.
module tb_multiply_seq;
   localparam int W  = 8;
   localparam int G  = 4;
   localparam int AW = 2*W + G;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   multiply_seq_if #(.WIDTH(W), .GUARD(G)) bus ();
   multiply_seq #(.WIDTH(W), .GUARD(G)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [W-1:0]    a;
      logic [W-1:0]    b;
      logic            sgn;
      logic [2*W-1:0]  y;
      logic [AW-1:0]   acc;
   } vec_t;

   vec_t vecs[8];

   // Waits for ready, launches one operation, returns results seen at done.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sgn, input logic accum, input logic clr,
                         output logic [2*W-1:0] y, output logic [AW-1:0] acc,
                         output logic ovf, output int lat);
      int w = 0;
      @(negedge clk);
      while (!bus.ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (w >= 20) check("ready_wait_timeout", 32'(w), 32'(0));
      bus.A = a; bus.B = b; bus.is_signed = sgn; bus.accumulate = accum;
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      lat = 0;
      while (!bus.done && lat < 20) begin
         bus.clear = clr && (lat == 7);
         @(negedge clk);
         lat++;
      end
      bus.clear = 1'b0;
      y   = bus.Y;
      acc = bus.acc;
      ovf = bus.overflow;
   endtask

   logic [2*W-1:0] y;
   logic [AW-1:0]  acc;
   logic           ovf;
   int             lat;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ndone, last_t, t, gap_ok, first_gap, second_gap;
      logic [2*W-1:0] y_seen;

      vecs[0] = '{a: 8'd200, b: 8'd150, sgn: 1'b0, y: 16'h7530, acc: 20'h07530};
      vecs[1] = '{a: 8'h80,  b: 8'h80,  sgn: 1'b1, y: 16'h4000, acc: 20'h04000};
      vecs[2] = '{a: 8'hFD,  b: 8'd5,   sgn: 1'b1, y: 16'hFFF1, acc: 20'hFFFF1};
      vecs[3] = '{a: 8'h7F,  b: 8'h80,  sgn: 1'b1, y: 16'hC080, acc: 20'hFC080};
      vecs[4] = '{a: 8'h00,  b: 8'hFF,  sgn: 1'b1, y: 16'h0000, acc: 20'h00000};
      vecs[5] = '{a: 8'hFF,  b: 8'hFF,  sgn: 1'b0, y: 16'hFE01, acc: 20'h0FE01};
      vecs[6] = '{a: 8'h80,  b: 8'hFF,  sgn: 1'b1, y: 16'h0080, acc: 20'h00080};
      vecs[7] = '{a: 8'h80,  b: 8'h80,  sgn: 1'b0, y: 16'h4000, acc: 20'h04000};

      bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.is_signed = 1'b0;
      bus.accumulate = 1'b0; bus.clear = 1'b0;
      rst_n = 1'b0;
      #12;
      check("reset_ready", 32'(bus.ready), 32'd1);
      check("reset_done",  32'(bus.done),  32'd0);
      check("reset_y",     32'(bus.Y),     32'd0);
      check("reset_acc",   32'(bus.acc),   32'd0);
      check("reset_ovf",   32'(bus.overflow), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table of load-mode products, with latency and done/ready tail checks.
      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].sgn, 1'b0, 1'b0, y, acc, ovf, lat);
         check($sformatf("vec%0d_y", i),   32'(y),   32'(vecs[i].y));
         check($sformatf("vec%0d_acc", i), 32'(acc), 32'(vecs[i].acc));
         check($sformatf("vec%0d_lat", i), 32'(lat), 32'd8);
         @(negedge clk);
         check($sformatf("vec%0d_done_off", i), 32'(bus.done),  32'd0);
         check($sformatf("vec%0d_ready",    i), 32'(bus.ready), 32'd1);
      end

      // Signed accumulate must sign-extend the product.
      @(negedge clk); bus.clear = 1'b1;
      @(negedge clk); bus.clear = 1'b0;
      check("clear_acc", 32'(bus.acc), 32'd0);
      check("clear_ovf", 32'(bus.overflow), 32'd0);
      run_op(8'hFD, 8'd5, 1'b1, 1'b1, 1'b0, y, acc, ovf, lat);
      check("sacc1_acc", 32'(acc), 32'h000FFFF1);
      run_op(8'hFD, 8'd5, 1'b1, 1'b1, 1'b0, y, acc, ovf, lat);
      check("sacc2_acc", 32'(acc), 32'h000FFFE2);
      check("sacc2_ovf", 32'(ovf), 32'd0);

      // Unsigned accumulate up to carry-out of the 20-bit accumulator.
      @(negedge clk); bus.clear = 1'b1;
      @(negedge clk); bus.clear = 1'b0;
      for (int i = 1; i <= 17; i++) begin
         run_op(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, y, acc, ovf, lat);
         if (i == 16) begin
            check("acc16_acc", 32'(acc), 32'd1040400);
            check("acc16_ovf", 32'(ovf), 32'd0);
         end
      end
      check("acc17_acc", 32'(acc), 32'd56849);
      check("acc17_ovf", 32'(ovf), 32'd1);
      run_op(8'd2, 8'd3, 1'b0, 1'b0, 1'b0, y, acc, ovf, lat);
      check("load_acc", 32'(acc), 32'd6);
      check("load_ovf_sticky", 32'(ovf), 32'd1);

      // Clear coinciding with the completing edge drops the acc update only.
      run_op(8'd9, 8'd9, 1'b0, 1'b1, 1'b1, y, acc, ovf, lat);
      check("clrcol_y",    32'(y),   32'd81);
      check("clrcol_done", 32'(bus.done), 32'd1);
      check("clrcol_acc",  32'(acc), 32'd0);
      check("clrcol_ovf",  32'(ovf), 32'd0);

      // Start pulsed during CALC is ignored.
      @(negedge clk); @(negedge clk);
      bus.A = 8'd10; bus.B = 8'd10; bus.is_signed = 1'b0; bus.accumulate = 1'b0;
      bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      repeat (3) @(negedge clk);
      bus.A = 8'd7; bus.B = 8'd7; bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      ndone = 0; y_seen = '0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.done) begin ndone++; y_seen = bus.Y; end
      end
      check("busy_ndone", 32'(ndone), 32'd1);
      check("busy_y",     32'(y_seen), 32'd100);
      check("busy_ready", 32'(bus.ready), 32'd1);

      // Start held high: done every WIDTH+2 cycles.
      bus.A = 8'd3; bus.B = 8'd4; bus.start = 1'b1;
      ndone = 0; last_t = 0; first_gap = 0; second_gap = 0;
      for (int i = 0; i < 35; i++) begin
         @(negedge clk);
         t = i;
         if (bus.done) begin
            ndone++;
            if (ndone == 2) first_gap  = t - last_t;
            if (ndone == 3) second_gap = t - last_t;
            last_t = t;
         end
      end
      bus.start = 1'b0;
      gap_ok = (ndone >= 3) ? 1 : 0;
      check("held_ndone", 32'(gap_ok), 32'd1);
      check("held_gap1",  32'(first_gap),  32'd10);
      check("held_gap2",  32'(second_gap), 32'd10);

      // Reset during the 4th CALC cycle aborts with no done pulse.
      run_op(8'd1, 8'd5, 1'b0, 1'b0, 1'b0, y, acc, ovf, lat);
      @(negedge clk); @(negedge clk);
      bus.A = 8'd10; bus.B = 8'd10; bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk); bus.start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_mid_ready", 32'(bus.ready), 32'd1);
      check("rst_mid_y",     32'(bus.Y),     32'd0);
      check("rst_mid_acc",   32'(bus.acc),   32'd0);
      @(negedge clk); rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (bus.done) ndone++;
      end
      check("rst_mid_no_done", 32'(ndone), 32'd0);
      run_op(8'd6, 8'd7, 1'b0, 1'b0, 1'b0, y, acc, ovf, lat);
      check("post_rst_y",   32'(y),   32'd42);
      check("post_rst_lat", 32'(lat), 32'd8);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
